oam_dma_responder: RTL and testbench
====================================

Name: oam_dma_responder

Overview:
- Memory-side responder for the OAM DMA engine.
- Services DMA bus reads from the system source memory, which has a 1-cycle synchronous read. Realigns the engine's write stream into a local OAM array with a 1-cycle pipeline.
- Locks out the CPU (except HRAM) and the PPU for the duration of a transfer.
- Sits between the DMA engine, the system memory bus, the CPU bus and the PPU sprite fetcher.

Parameters:
- OAM_BASE, 16'hFE00, first OAM address.
- OAM_SIZE, 160, OAM bytes; also the transfer-count saturation value.
- HRAM_LO, 16'hFF80, lowest CPU address accessible during a transfer.
- HRAM_HI, 16'hFFFE, highest CPU address accessible during a transfer.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- dma_mode  in  1  high while the DMA engine is transferring.
- dma_raddr  in  16  DMA source address.
- dma_waddr  in  16  DMA destination address.
- dma_wdata  in  8  DMA write data; the engine forwards dma_rdata here.
- dma_re  in  1  DMA read strobe.
- dma_we  in  1  DMA write strobe.
- dma_rdata  out  8  source data returned to the engine.
- src_addr  out  16  system-memory read address.
- src_re  out  1  system-memory read enable.
- src_rdata  in  8  system-memory data, valid 1 cycle after src_addr/src_re.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_re  in  1  CPU read strobe.
- cpu_rdata  out  8  CPU read data.
- cpu_block  out  1  high when the current CPU access is refused.
- ppu_addr  in  8  OAM byte index for sprite fetch.
- ppu_rdata  out  8  registered OAM read data.
- xfer_count  out  8  OAM bytes written in the current/last transfer.
- xfer_done  out  1  1-cycle pulse at transfer completion.
- xfer_err  out  1  sticky flag: a DMA write addressed outside OAM.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pipeline valid=0, xfer_count=0, xfer_done=0, xfer_err=0, ppu_rdata=8'hFF, cpu_block=0.
  - OAM contents are not cleared.
  - Reset mid-transfer abandons the in-flight byte; no write occurs.
- Source path (combinational):
  - src_addr = dma_raddr.
  - src_re = dma_re.
  - dma_rdata = src_rdata.
- Write pipeline:
  - Each cycle with dma_we=1, register dma_waddr and set valid.
  - Next cycle: if valid, write dma_wdata to OAM[waddr_q - OAM_BASE] and increment xfer_count (saturates at OAM_SIZE).
  - A registered waddr outside OAM_BASE..OAM_BASE+OAM_SIZE-1 is dropped and sets xfer_err.
  - Net latency: source byte read at cycle t lands in OAM at the end of cycle t+1.
- State machine:
  - IDLE -> ACTIVE on dma_mode=1; xfer_count cleared to 0 on this transition, xfer_err cleared too.
  - ACTIVE stays while dma_mode=1.
  - ACTIVE -> DRAIN on dma_mode=0; DRAIN performs the final pipelined write.
  - DRAIN -> IDLE unconditionally; xfer_done=1 for exactly the DRAIN->IDLE cycle.
  - dma_mode re-asserting during DRAIN is honoured only from IDLE on the following cycle.
- busy = (state != IDLE).
- CPU access:
  - busy and address in HRAM_LO..HRAM_HI: cpu_block=0, cpu_rdata=8'hZZ; the access passes to the HRAM owner.
  - busy and any other address with cpu_re|cpu_we: cpu_block=1, reads return 8'hFF, writes dropped.
  - Not busy and address in OAM range:
    - Read: cpu_rdata = OAM byte, combinational.
    - Write: OAM byte updated at the clock edge.
  - Otherwise cpu_rdata=8'hZZ and cpu_block=0.
  - cpu_we has priority over cpu_re.
- PPU access:
  - ppu_rdata is registered: OAM[ppu_addr] one cycle later.
  - Returns 8'hFF when busy during the sampling cycle, or when ppu_addr >= OAM_SIZE.
- Simultaneous events: a CPU OAM write in the same cycle that IDLE->ACTIVE occurs is performed, since the CPU is not yet blocked.

Optional Feature:
- Macro: DMA_ECHO_FOLD_EN.
- When defined: a dma_raddr in 16'hE000..16'hFFFF is issued on src_addr as dma_raddr - 16'h2000, so echo-RAM and high sources read WRAM.
- When undefined: src_addr = dma_raddr unmodified.

Test Plan:
- Write 0xC0 to DMA with source C000..C09F preloaded with i^0x5A -> OAM[i] = i^0x5A for i=0..159; xfer_count=160; xfer_done pulses once, 2 cycles after dma_mode falls.
- CPU read FF80 and read C000 mid-transfer -> FF80: cpu_block=0, cpu_rdata=ZZ; C000: cpu_block=1, cpu_rdata=8'hFF; CPU write FE10=0x33 mid-transfer -> OAM[16] unchanged.
- PPU reads ppu_addr=5 while busy -> ppu_rdata=8'hFF; after IDLE -> OAM[5] one cycle later.
- Assert Reset at byte 80 -> state IDLE immediately, xfer_count=0, OAM[0..79] hold new data, OAM[80..159] keep old data.
- DMA write with dma_waddr=16'hFEA0 -> no OAM write, xfer_err=1 until next transfer start.
- DMA_ECHO_FOLD_EN defined, source E000 -> src_addr=C000..C09F; undefined -> src_addr=E000..E09F.

Source files
------------

// File: rtl/oam_dma_responder.sv
// Memory-side responder for the OAM DMA engine: source read path, write realignment, OAM array, CPU/PPU lockout.
// Optional define DMA_ECHO_FOLD_EN folds DMA sources at E000..FFFF down by 0x2000 onto WRAM.
module oam_dma_responder #(
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter int          OAM_SIZE = 160,
  parameter logic [15:0] HRAM_LO  = 16'hFF80,
  parameter logic [15:0] HRAM_HI  = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_mode,
  input  logic [15:0] dma_raddr,
  input  logic [15:0] dma_waddr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_re,
  input  logic        dma_we,
  output logic [7:0]  dma_rdata,
  output logic [15:0] src_addr,
  output logic        src_re,
  input  logic [7:0]  src_rdata,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_block,
  input  logic [7:0]  ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [7:0]  xfer_count,
  output logic        xfer_done,
  output logic        xfer_err
);

  localparam logic [15:0] OAM_LAST   = OAM_BASE + 16'(OAM_SIZE - 1);
  localparam logic [7:0]  OAM_SIZE_B = 8'(OAM_SIZE);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] waddr_q, waddr_d;
  logic [7:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  ppu_q, ppu_d;

  logic [7:0]  oam_mem [OAM_SIZE];

  logic        busy;
  logic        dma_in_oam, dma_wr_en;
  logic [7:0]  dma_idx;
  logic        cpu_in_oam, cpu_in_hram, cpu_blocked;
  logic        cpu_oam_wr, cpu_oam_rd, cpu_rd_drive;
  logic [7:0]  cpu_idx, cpu_rd_val;

  // Source path is purely combinational; the engine sees memory latency directly.
`ifdef DMA_ECHO_FOLD_EN
  assign src_addr = (dma_raddr >= 16'hE000) ? (dma_raddr - 16'h2000) : dma_raddr;
`else
  assign src_addr = dma_raddr;
`endif
  assign src_re    = dma_re;
  assign dma_rdata = src_rdata;

  assign busy        = (state_q != IDLE);
  assign dma_in_oam  = (waddr_q >= OAM_BASE) && (waddr_q <= OAM_LAST);
  assign dma_wr_en   = wr_valid_q && dma_in_oam;
  assign dma_idx     = 8'(waddr_q - OAM_BASE);

  assign cpu_in_oam  = (cpu_addr >= OAM_BASE) && (cpu_addr <= OAM_LAST);
  assign cpu_in_hram = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
  assign cpu_idx     = 8'(cpu_addr - OAM_BASE);
  assign cpu_blocked = busy && !cpu_in_hram && (cpu_re || cpu_we);
  assign cpu_oam_wr  = !busy && cpu_in_oam && cpu_we;
  assign cpu_oam_rd  = !busy && cpu_in_oam && cpu_re && !cpu_we;

  assign cpu_block    = cpu_blocked;
  assign cpu_rd_drive = cpu_blocked || cpu_oam_rd;
  assign cpu_rd_val   = cpu_blocked ? 8'hFF : oam_mem[cpu_idx];
  // Undriven cycles float so the HRAM owner (or nobody) can drive the shared bus.
  assign cpu_rdata    = cpu_rd_drive ? cpu_rd_val : 8'hzz;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    count_d    = count_q;
    err_d      = err_q;
    done_d     = 1'b0;
    wr_valid_d = dma_we;
    waddr_d    = dma_we ? dma_waddr : waddr_q;

    case (state_q)
      IDLE: begin
        if (dma_mode) begin
          state_d = ACTIVE;
          count_d = 8'd0;
          err_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (!dma_mode) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (wr_valid_q) begin
      if (dma_in_oam) begin
        if (count_d != OAM_SIZE_B) count_d = count_d + 8'd1;
      end else begin
        err_d = 1'b1;
      end
    end

    ppu_d = (busy || (ppu_addr >= OAM_SIZE_B)) ? 8'hFF : oam_mem[ppu_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_valid_q <= 1'b0;
      waddr_q    <= 16'h0000;
      count_q    <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ppu_q      <= 8'hFF;
    end else begin
      state_q    <= state_d;
      wr_valid_q <= wr_valid_d;
      waddr_q    <= waddr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ppu_q      <= ppu_d;
    end
  end

  // NOTE: the OAM array has no reset; contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (cpu_oam_wr) oam_mem[cpu_idx] <= cpu_wdata;
    if (dma_wr_en)  oam_mem[dma_idx] <= dma_wdata;
  end

  assign ppu_rdata  = ppu_q;
  assign xfer_count = count_q;
  assign xfer_done  = done_q;
  assign xfer_err   = err_q;

endmodule

// File: tb/tb_oam_dma_responder.sv
// Scoreboard bench for oam_dma_responder: stimulus pushes expectations, a negedge monitor compares them.
module tb_oam_dma_responder;

  localparam logic [15:0] OAM_BASE = 16'hFE00;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_mode, dma_re, dma_we;
  logic [15:0] dma_raddr, dma_waddr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [15:0] src_addr;
  logic        src_re;
  logic [7:0]  src_rdata = 8'h00;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we, cpu_re;
  wire  [7:0]  cpu_rdata;
  logic        cpu_block;
  logic [7:0]  ppu_addr, ppu_rdata, xfer_count;
  logic        xfer_done, xfer_err;

  oam_dma_responder dut (
    .clk(clk), .rst(rst), .dma_mode(dma_mode), .dma_raddr(dma_raddr),
    .dma_waddr(dma_waddr), .dma_wdata(dma_wdata), .dma_re(dma_re), .dma_we(dma_we),
    .dma_rdata(dma_rdata), .src_addr(src_addr), .src_re(src_re), .src_rdata(src_rdata),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_block(cpu_block), .ppu_addr(ppu_addr),
    .ppu_rdata(ppu_rdata), .xfer_count(xfer_count), .xfer_done(xfer_done),
    .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  // Source memory with a 1-cycle synchronous read; the engine forwards read data as write data.
  logic [7:0] smem [65536];
  always @(posedge clk) if (src_re) src_rdata <= smem[src_addr];
  assign dma_wdata = dma_rdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic [2:0] {S_CNT, S_ERR, S_PPU, S_CPU_RD, S_CPU_BLK, S_SRC_ADDR, S_DMA_RDATA} sig_e;
  typedef struct packed {
    int          due;
    sig_e        sig;
    logic [15:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a >= 16'hC000 && a < 16'hC0A0) return 8'(a - 16'hC000) ^ 8'h5A;
    if (a >= 16'hC100 && a < 16'hC1A0) return 8'(a - 16'hC100) ^ 8'hC3;
    if (a >= 16'hE000 && a < 16'hE0A0) return 8'(a - 16'hE000) ^ 8'h3C;
    return 8'h00;
  endfunction

  function automatic logic [15:0] fold(input logic [15:0] a);
`ifdef DMA_ECHO_FOLD_EN
    return (a >= 16'hE000) ? a - 16'h2000 : a;
`else
    return a;
`endif
  endfunction

  function automatic logic [15:0] actual(input sig_e s);
    case (s)
      S_CNT:       return {8'h00, xfer_count};
      S_ERR:       return {15'h0000, xfer_err};
      S_PPU:       return {8'h00, ppu_rdata};
      S_CPU_RD:    return {8'h00, cpu_rdata};
      S_CPU_BLK:   return {15'h0000, cpu_block};
      S_SRC_ADDR:  return src_addr;
      S_DMA_RDATA: return {8'h00, dma_rdata};
      default:     return 16'hDEAD;
    endcase
  endfunction

  task automatic expect_at(input int dly, input sig_e s, input logic [15:0] e);
    exp_t t;
    t.due = cyc + dly;
    t.sig = s;
    t.exp = e;
    exp_q.push_back(t);
  endtask

  // Monitor: compares every expectation due this cycle and every xfer_done pulse.
  always @(negedge clk) begin
    int j;
    logic [15:0] act;
    j = 0;
    while (j < exp_q.size()) begin
      if (exp_q[j].due <= cyc) begin
        act = actual(exp_q[j].sig);
        total++;
        if (exp_q[j].due < cyc || act !== exp_q[j].exp) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h", exp_q[j].sig.name(), cyc, act, exp_q[j].exp);
        end
        exp_q.delete(j);
      end else begin
        j++;
      end
    end
    if (xfer_done === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL xfer_done unexpected pulse cyc=%0d", cyc);
      end else begin
        int d;
        d = done_q.pop_front();
        if (d != cyc) begin
          bad++;
          $display("FAIL xfer_done cyc got=%0d want=%0d", cyc, d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dma_re = 1'b0; dma_we = 1'b0;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    ppu_addr = 8'h00;
  endtask

  task automatic sweep(input logic [15:0] lo_src, input logic [15:0] hi_src, input int split);
    for (int i = 0; i < 160; i++) begin
      step(); idle();
      cpu_addr = OAM_BASE + 16'(i);
      cpu_re   = 1'b1;
      expect_at(0, S_CPU_RD, {8'h00, pat(((i < split) ? lo_src : hi_src) + 16'(i))});
    end
    step(); idle();
  endtask

  task automatic run_xfer(input logic [15:0] sbase, input int n, input int abort_at, input bit probes);
    for (int i = 0; i <= n; i++) begin
      step(); idle();
      dma_mode = 1'b1;
      if (i == abort_at) begin
        rst = 1'b1; dma_mode = 1'b0;
        cpu_re = 1'b1; cpu_addr = 16'hC000; ppu_addr = 8'd5;
        expect_at(0, S_CNT, 16'd0);
        expect_at(0, S_CPU_BLK, 16'd0);
        expect_at(0, S_PPU, 16'h00FF);
        step(); rst = 1'b0; idle();
        return;
      end
      if (i < n) begin
        dma_re    = 1'b1; dma_raddr = sbase + 16'(i % 160);
        dma_we    = 1'b1; dma_waddr = OAM_BASE + 16'(i % 160);
        if (i == 0 || i == 1 || i == 159) expect_at(0, S_SRC_ADDR, fold(dma_raddr));
      end
      if (i == 1) begin
        expect_at(0, S_DMA_RDATA, {8'h00, pat(fold(sbase))});
        expect_at(0, S_CNT, 16'd0);
        expect_at(0, S_ERR, 16'd0);
      end
      if (i == 2) expect_at(0, S_CNT, 16'd1);
      if (probes) begin
        case (i)
          10: begin cpu_re = 1'b1; cpu_addr = 16'hFF80; expect_at(0, S_CPU_BLK, 16'd0); end
          11: begin
            cpu_re = 1'b1; cpu_addr = 16'hC000;
            expect_at(0, S_CPU_BLK, 16'd1); expect_at(0, S_CPU_RD, 16'h00FF);
          end
          12: begin cpu_we = 1'b1; cpu_addr = 16'hFE10; cpu_wdata = 8'h33; expect_at(0, S_CPU_BLK, 16'd1); end
          13: begin ppu_addr = 8'd5; expect_at(1, S_PPU, 16'h00FF); end
          default: ;
        endcase
      end
    end
    step(); idle();
    dma_mode = 1'b0;
    done_q.push_back(cyc + 2);
    step(); step(); step(); idle();
  endtask

  initial begin
    rst = 1'b1; dma_mode = 1'b0; dma_raddr = 16'h0000; dma_waddr = 16'h0000;
    idle();
    for (int a = 0; a < 65536; a++) smem[a] = pat(16'(a));
    step(); step();
    cpu_re = 1'b1; cpu_addr = 16'hC000;
    expect_at(0, S_CNT, 16'd0);
    expect_at(0, S_ERR, 16'd0);
    expect_at(0, S_PPU, 16'h00FF);
    expect_at(0, S_CPU_BLK, 16'd0);
    step(); rst = 1'b0; idle();

    // Old OAM image written by the CPU while idle.
    for (int i = 0; i < 160; i++) begin
      step(); idle();
      cpu_addr = OAM_BASE + 16'(i); cpu_we = 1'b1; cpu_wdata = 8'(i) ^ 8'hA5;
    end
    step(); idle();

    // Full transfer from C000 with lockout probes.
    run_xfer(16'hC000, 160, -1, 1'b1);
    expect_at(0, S_CNT, 16'd160);
    sweep(16'hC000, 16'hC000, 160);
    ppu_addr = 8'd5;   expect_at(1, S_PPU, {8'h00, pat(16'hC005)});
    step(); idle();
    ppu_addr = 8'd159; expect_at(1, S_PPU, {8'h00, pat(16'hC09F)});
    step(); idle();
    ppu_addr = 8'd160; expect_at(1, S_PPU, 16'h00FF);
    cpu_re = 1'b1; cpu_addr = 16'hC000; expect_at(0, S_CPU_BLK, 16'd0);
    step(); idle();

    // DMA write outside OAM: dropped, sticky error.
    step(); idle(); dma_mode = 1'b1;
    step(); idle(); dma_mode = 1'b1;
    expect_at(0, S_CNT, 16'd0);
    dma_we = 1'b1; dma_waddr = 16'hFEA0; dma_re = 1'b1; dma_raddr = 16'hC000;
    step(); idle(); dma_mode = 1'b1;
    step(); idle(); dma_mode = 1'b1;
    expect_at(0, S_ERR, 16'd1); expect_at(0, S_CNT, 16'd0);
    step(); idle(); dma_mode = 1'b0;
    done_q.push_back(cyc + 2);
    step(); step(); step(); idle();
    expect_at(0, S_ERR, 16'd1);
    cpu_re = 1'b1; cpu_addr = 16'hFE9F; expect_at(0, S_CPU_RD, {8'h00, pat(16'hC09F)});
    step(); idle();

    // Transfer from C100 abandoned by reset with byte 80 in flight.
    run_xfer(16'hC100, 160, 81, 1'b0);
    sweep(16'hC100, 16'hC000, 80);

    // Echo-region source, 162 writes to exercise count saturation.
    run_xfer(16'hE000, 162, -1, 1'b0);
    expect_at(0, S_CNT, 16'd160);
    expect_at(0, S_ERR, 16'd0);
    sweep(fold(16'hE000), fold(16'hE000), 160);

    step(); step(); step();
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      $display("FAIL leftover expectations checks=%0d done=%0d", exp_q.size(), done_q.size());
      total += exp_q.size() + done_q.size();
      bad   += exp_q.size() + done_q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
